// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game core: FSM states, Galois LFSR tap masks
// and a width helper.
package simon_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShowOn,
      StShowOff,
      StWaitIn,
      StFail,
      StWin
   } state_e;

   // Right-shifting Galois masks: bit k-1 set for each x^k term (x^0 excluded).
   localparam logic [7:0]  TAPS8  = 8'hB8;
   localparam logic [15:0] TAPS16 = 16'hB400;
   localparam logic [23:0] TAPS24 = 24'hE10000;
   localparam logic [31:0] TAPS32 = 32'h80200003;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic logic [31:0] taps_for(input int unsigned w);
      case (w)
         8:       return {24'd0, TAPS8};
         24:      return {8'd0, TAPS24};
         32:      return TAPS32;
         default: return {16'd0, TAPS16};
      endcase
   endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Galois LFSR with synchronous parallel load; load takes priority over step.
module simon_lfsr #(
   parameter int unsigned   W    = 16,
   parameter logic [W-1:0] TAPS = 16'hB400,
   parameter logic [W-1:0] INIT = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         step,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= INIT;
      end else if (load) begin
         q <= din;
      end else if (step) begin
         q <= (q >> 1) ^ (q[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/simon_engine.sv
// Simon game core: replays a growing prefix of an LFSR-derived symbol sequence, then checks
// the player's entries against it, tracking score, best score, loss and win.
module simon_engine
   import simon_pkg::*;
#(
   parameter int unsigned        SYM_W      = 4,
   parameter int unsigned        MAX_ROUNDS = 39,
   parameter int unsigned        LFSR_W     = 16,
   parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
   parameter int unsigned        SHOW_TICKS = 1,
   parameter int unsigned        GAP_TICKS  = 1,
   localparam int unsigned       RND_W      = clog2(MAX_ROUNDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start,
   input  logic             submit,
   input  logic [SYM_W-1:0] guess,
   output logic [SYM_W-1:0] sym_out,
   output logic             sym_valid,
   output logic             first_flag,
   output logic             await_input,
   output logic [RND_W-1:0] round,
   output logic [RND_W-1:0] best,
   output logic             game_over,
   output logic             win
);

   localparam int unsigned        MAX_T = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
   localparam int unsigned        CNT_W = clog2(MAX_T + 1);
   localparam logic [CNT_W-1:0]   SHOW_C = CNT_W'(SHOW_TICKS);
   localparam logic [CNT_W-1:0]   GAP_C  = CNT_W'(GAP_TICKS);
   localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);
   localparam logic [RND_W-1:0]   MAX_R  = RND_W'(MAX_ROUNDS);
   localparam logic [RND_W-1:0]   ONE_R  = RND_W'(1);
   localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(taps_for(LFSR_W));

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RND_W-1:0]    idx_q, idx_d;
   logic [RND_W-1:0]    round_d, best_d;
   logic                game_over_d, win_d;
   logic [LFSR_W-1:0]   seed_q, seed_d;
   logic [LFSR_W-1:0]   free_q, play_q, play_nxt;
   logic                play_load, play_step;
   logic                sym_valid_d;

   simon_lfsr #(.W(LFSR_W), .TAPS(TAPS), .INIT(SEED)) u_free (
      .clk  (clk),
      .rst  (rst),
      .load (1'b0),
      .din  ('0),
      .step (1'b1),
      .q    (free_q)
   );

   simon_lfsr #(.W(LFSR_W), .TAPS(TAPS), .INIT(SEED)) u_play (
      .clk  (clk),
      .rst  (rst),
      .load (play_load),
      .din  (seed_q),
      .step (play_step),
      .q    (play_q)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      round_d     = round;
      best_d      = best;
      game_over_d = game_over;
      win_d       = win;
      seed_d      = seed_q;
      play_load   = 1'b0;
      play_step   = 1'b0;

      if (start) begin
         state_d     = StLoad;
         round_d     = '0;
         game_over_d = 1'b0;
         win_d       = 1'b0;
         seed_d      = free_q;
      end else begin
         unique case (state_q)
            StLoad: begin
               play_load = 1'b1;
               idx_d     = '0;
               state_d   = StShowOn;
            end
            StShowOn: begin
               if (cnt_q == SHOW_C) state_d = StShowOff;
               else if (tick)       cnt_d   = cnt_q + ONE_C;
            end
            StShowOff: begin
               if (cnt_q == GAP_C) begin
                  if (idx_q == round) begin
                     play_load = 1'b1;
                     idx_d     = '0;
                     state_d   = StWaitIn;
                  end else begin
                     play_step = 1'b1;
                     idx_d     = idx_q + ONE_R;
                     state_d   = StShowOn;
                  end
               end else if (tick) begin
                  cnt_d = cnt_q + ONE_C;
               end
            end
            StWaitIn: begin
               if (submit) begin
                  if (guess != play_q[SYM_W-1:0]) begin
                     game_over_d = 1'b1;
                     state_d     = StFail;
                  end else if (idx_q != round) begin
                     play_step = 1'b1;
                     idx_d     = idx_q + ONE_R;
                  end else begin
                     round_d = round + ONE_R;
                     if (round_d > best) best_d = round_d;
                     if (round_d == MAX_R) begin
                        win_d   = 1'b1;
                        state_d = StWin;
                     end else begin
                        state_d = StLoad;
                     end
                  end
               end
            end
            StIdle, StFail, StWin: ;
            default: state_d = StIdle;
         endcase
      end

      if (state_d != state_q) cnt_d = '0;
   end

   // Registered display outputs are computed from next-state values so they align with state.
   always_comb begin
      play_nxt = play_q;
      if (play_load)      play_nxt = seed_q;
      else if (play_step) play_nxt = (play_q >> 1) ^ (play_q[0] ? TAPS : '0);
      sym_valid_d = (state_d == StShowOn);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         seed_q      <= SEED;
         round       <= '0;
         best        <= '0;
         game_over   <= 1'b0;
         win         <= 1'b0;
         sym_out     <= '0;
         sym_valid   <= 1'b0;
         first_flag  <= 1'b0;
         await_input <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         seed_q      <= seed_d;
         round       <= round_d;
         best        <= best_d;
         game_over   <= game_over_d;
         win         <= win_d;
         sym_out     <= sym_valid_d ? play_nxt[SYM_W-1:0] : '0;
         sym_valid   <= sym_valid_d;
         first_flag  <= sym_valid_d && (idx_d == '0);
         await_input <= (state_d == StWaitIn);
      end
   end

endmodule

// File: doc/simon_engine.md
# simon_engine

Parametrised Simon-game core: generates a pseudo-random symbol sequence, plays back a growing prefix of it one symbol per display slot, then checks the player's entered symbols against the same prefix. It adds a win condition, best-score tracking and tick-enable pacing, and regenerates the sequence from a captured seed rather than storing it. It sits between board I/O (synchronised, debounced buttons and switches; LEDs) and the seven-segment score decoders, all in the single `clk` domain.

## Interface
- `SYM_W`, 4: symbol width. One bit per LED / switch. Must satisfy 1 ≤ `SYM_W` ≤ `LFSR_W`.
- `MAX_ROUNDS`, 39: completed-round count that wins the game. Must be ≥ 1.
- `LFSR_W`, 16: LFSR width.
- `SEED`, 16'hACE1: reset value of the free-running LFSR. Must be nonzero.
- `SHOW_TICKS`, 1: tick pulses each symbol is displayed. Must be ≥ 1.
- `GAP_TICKS`, 1: tick pulses of blank between symbols. Must be ≥ 1.
- `RND_W` (derived) = $clog2(`MAX_ROUNDS`+1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `tick`  in  1  one-cycle pacing enable (e.g. 1 Hz pulse).
- `start`  in  1  one-cycle pulse: begin a new game.
- `submit`  in  1  one-cycle pulse: enter `guess`.
- `guess`  in  `SYM_W`  player symbol (switches).
- `sym_out`  out  `SYM_W`  displayed symbol; 0 when `sym_valid`=0.
- `sym_valid`  out  1  playback symbol is shown.
- `first_flag`  out  1  high while the first symbol of a playback is shown.
- `await_input`  out  1  player entry phase.
- `round`  out  `RND_W`  current score (completed rounds).
- `best`  out  `RND_W`  highest score since reset.
- `game_over`  out  1  level; set on a wrong guess, cleared by `start`.
- `win`  out  1  level; set on reaching `MAX_ROUNDS`, cleared by `start`.

## Operation
- Free LFSR (Galois, taps from package) steps every `clk`. On `start`, its current value is captured as `game_seed`.
- Replay LFSR: each symbol = `play_lfsr[SYM_W-1:0]`; advance one step per symbol.
- States:
  - IDLE → LOAD on `start`.
  - LOAD (1 clk): set `play_lfsr`=`game_seed` and `idx`=0 → SHOW_ON.
  - SHOW_ON: display the symbol; after `SHOW_TICKS` ticks → SHOW_OFF.
  - SHOW_OFF: after `GAP_TICKS` ticks, step the LFSR and increment `idx`. If the old `idx` equalled `round` → WAIT_IN, with `play_lfsr` reloaded and `idx`=0; else → SHOW_ON.
  - WAIT_IN: `await_input`=1. On `submit`:
    - `guess`≠symbol → FAIL.
    - Match and `idx`<`round`: step the LFSR and increment `idx`.
    - Match and `idx`==`round`: increment `round`; → WIN if the new `round`==`MAX_ROUNDS`, else → LOAD.
  - FAIL / WIN: hold `game_over` / `win`; → LOAD on `start`.
- Playback length = `round`+1 symbols. Each round's playback is a strict extension of the previous round's.
- `best` updates to `round`+1 in the same cycle `round` increments, if that exceeds `best`. Only `rst` clears `best`.
- `start` in any state restarts the game: `round`=0, flags cleared, new seed captured. If `start` and `submit` coincide, `start` wins.
- `submit` outside WAIT_IN is ignored. `tick` outside SHOW_ON/SHOW_OFF is ignored.
- After FAIL, `round` holds the failing score until the next `start`.

## Timing
- Reset values: all outputs 0; state IDLE; free LFSR = `SEED`; `game_seed` = `SEED`.
- `rst` mid-game clears everything asynchronously, with no pending effects.
- Outputs are registered.
- `start` at edge N → LOAD at N+1 → `sym_valid`=1 at N+2.
- In SHOW_ON, a tick at edge T is counted at T. The final counted tick moves the state at T+1.
- `submit` at edge S updates `round`, `game_over` and `win` at S+1.
- Tick counter width = $clog2(max(`SHOW_TICKS`,`GAP_TICKS`)+1). It resets on every state entry.

## Structure
- Package `simon_pkg`:
  - state enum.
  - LFSR tap constants for widths 8/16/24/32 (16: x^16+x^14+x^13+x^11+1).
  - `clog2` helper for derived widths.
- Sub-module `simon_lfsr` (`W`, `TAPS`, `INIT`; `load`, `din`, `step`, `q`), instantiated twice (free, replay).
- Seven-segment decoding lives outside this block.

## Test plan
Bench parameters: `SYM_W`=4, `MAX_ROUNDS`=3, `SHOW_TICKS`=2, `GAP_TICKS`=1; `tick` every 4 clk; golden LFSR model in bench.
- Reset, then `submit` with `guess`=4'hF → all outputs 0, state IDLE, `round`=0.
- `start` → exactly 1 symbol for 2 ticks with `first_flag`=1 and `sym_out`=model(`game_seed`)[3:0], then a 1-tick gap, then `await_input`=1.
- Correct guess → `round`=1, `best`=1, 2-symbol playback whose first symbol is unchanged from round 0.
- In round 2, correct `idx`0, wrong `idx`1 → `game_over`=1, `round`=2, `best`=2. Then `start` → `round`=0, `game_over`=0, `best`=2.
- Three correct rounds → `win`=1, `round`=3, `best`=3, `await_input`=0, and further `submit` is ignored.
- `rst` pulsed mid SHOW_ON → `sym_valid`, `round` and `best` read 0 before the next `clk` edge.
